jtframe_ram_nslots_arb: RTL

- Parametrised N-slot SDRAM access arbiter for one SDRAM bank; successor to the fixed three-slot multiplexer.
- Takes pre-offset request addresses from up to 8 slots, picks one under fixed-priority or round-robin policy, drives the SDRAM controller handshake, and routes the returned word back to the granted slot.
- Adds an anti-starvation aging counter and a one-request-in-flight tracker with explicit states.
- Slot 0 is the only slot that can write.

---
 rtl/jtframe_arb_pkg.sv | 39 +++
 rtl/jtframe_arb_age.sv | 61 ++++++
 rtl/jtframe_ram_nslots_arb.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/jtframe_arb_pkg.sv
// Shared definitions for the N-slot SDRAM arbiter.
//   IDLE/CMD/DATA : state encoding of the access tracker
//   IDXW          : width of a slot index (up to 8 slots)
//   onehot()      : slot index to one-hot grant vector
//   rr_pick()     : round-robin winner search starting at a pointer
package jtframe_arb_pkg;

    localparam int IDXW = 3;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CMD  = 2'd1;
    localparam logic [1:0] DATA = 2'd2;

    function automatic logic [7:0] onehot(input logic [IDXW-1:0] idx, input int n);
        logic [7:0] v;
        v = '0;
        if (int'(idx) < n) v[idx] = 1'b1;
        return v;
    endfunction

    // Requests above NSLOTS are zero-padded, so a mod-8 scan from a pointer
    // below NSLOTS visits the live slots in the same order as a mod-NSLOTS scan.
    function automatic logic [IDXW-1:0] rr_pick(input logic [7:0] req, input logic [IDXW-1:0] ptr);
        logic [IDXW-1:0] idx;
        logic [IDXW-1:0] pick;
        logic            found;
        pick  = ptr;
        found = 1'b0;
        for (int i = 0; i < 8; i++) begin
            idx = ptr + IDXW'(i);
            if (!found && req[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/jtframe_arb_age.sv
// Anti-starvation aging counters, one per slot.
//   clk, rst_n : clock, asynchronous active-low reset
//   slot_req   : per-slot request levels
//   grant_en   : high in the cycle a grant is latched
//   win_idx    : index of the slot being granted
//   aged_any   : some requesting slot has waited MAXWAIT grants or more
//   aged_idx   : lowest-index such slot
module jtframe_arb_age
    import jtframe_arb_pkg::*;
#(
    parameter int NSLOTS  = 4,
    parameter int MAXWAIT = 15,
    parameter int AGEW    = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NSLOTS-1:0] slot_req,
    input  logic              grant_en,
    input  logic [IDXW-1:0]   win_idx,
    output logic              aged_any,
    output logic [IDXW-1:0]   aged_idx
);

    logic [AGEW-1:0] age_q [NSLOTS];
    logic [AGEW-1:0] age_d [NSLOTS];

    // Counters only move on a grant: losers that still request age by one
    // (saturating), the winner and idle slots restart from zero.
    always_comb begin
        for (int i = 0; i < NSLOTS; i++) begin
            age_d[i] = age_q[i];
            if (grant_en) begin
                if (!slot_req[i] || win_idx == IDXW'(i))
                    age_d[i] = '0;
                else if (age_q[i] != '1)
                    age_d[i] = age_q[i] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NSLOTS; i++) age_q[i] <= '0;
        end else begin
            for (int i = 0; i < NSLOTS; i++) age_q[i] <= age_d[i];
        end
    end

    // Descending scan so the lowest aged index is the one left standing.
    always_comb begin
        aged_any = 1'b0;
        aged_idx = '0;
        for (int i = NSLOTS - 1; i >= 0; i--) begin
            if (slot_req[i] && age_q[i] >= AGEW'(MAXWAIT)) begin
                aged_any = 1'b1;
                aged_idx = IDXW'(i);
            end
        end
    end

endmodule

// File: rtl/jtframe_ram_nslots_arb.sv
// N-slot SDRAM access arbiter for one bank. Picks one requesting slot
// (aged slots first, then round-robin or fixed priority), issues one
// read/write to the SDRAM controller and returns the result to that slot.
// Only slot 0 can write.
//   slot_req/slot_addr           : per-slot request level and word address
//   slot0_wen/din/wrmask         : slot 0 write controls
//   slot_grant/slot_rdy/slot_dout: one-hot grant, completion pulse, read word
//   sdram_*/data_*               : controller command and response side
// Handshake: a slot holds slot_req until its slot_rdy pulse; the arbiter
// holds sdram_rd/sdram_wr until sdram_ack, then waits for data_rdy (which
// may coincide with sdram_ack) to complete the single in-flight access.
module jtframe_ram_nslots_arb
    import jtframe_arb_pkg::*;
#(
    parameter int SDRAMW  = 22,
    parameter int NSLOTS  = 4,
    parameter int RR      = 1,
    parameter int MAXWAIT = 15,
    parameter int AGEW    = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NSLOTS-1:0]        slot_req,
    input  logic [NSLOTS*SDRAMW-1:0] slot_addr,
    input  logic                     slot0_wen,
    input  logic [15:0]              slot0_din,
    input  logic [1:0]               slot0_wrmask,
    output logic [NSLOTS-1:0]        slot_grant,
    output logic [NSLOTS-1:0]        slot_rdy,
    output logic [15:0]              slot_dout,
    input  logic                     sdram_ack,
    output logic                     sdram_rd,
    output logic                     sdram_wr,
    output logic [SDRAMW-1:0]        sdram_addr,
    input  logic                     data_dst,
    input  logic                     data_rdy,
    input  logic [15:0]              data_read,
    output logic [15:0]              data_write,
    output logic [1:0]               sdram_wrmask
);

    logic [1:0]        state_q, state_d;
    logic [NSLOTS-1:0] grant_q, grant_d;
    logic [NSLOTS-1:0] rdy_q, rdy_d;
    logic [15:0]       dout_q, dout_d;
    logic [15:0]       wdata_q, wdata_d;
    logic              rd_q, rd_d;
    logic              wr_q, wr_d;
    logic              is_wr_q, is_wr_d;
    logic [SDRAMW-1:0] addr_q, addr_d;
    logic [1:0]        mask_q, mask_d;
    logic [IDXW-1:0]   ptr_q, ptr_d;

    logic [IDXW-1:0]   win_idx, rr_idx, low_idx, aged_idx;
    logic              aged_any, grant_en, complete;
    logic [7:0]        req_pad;
    logic              unused_data_dst;

    assign unused_data_dst = data_dst;
    assign req_pad  = 8'(slot_req);
    assign grant_en = (state_q == IDLE) && (|slot_req);

    always_comb begin
        low_idx = '0;
        for (int i = NSLOTS - 1; i >= 0; i--)
            if (slot_req[i]) low_idx = IDXW'(i);
    end

    assign rr_idx  = rr_pick(req_pad, ptr_q);
    assign win_idx = aged_any ? aged_idx : ((RR != 0) ? rr_idx : low_idx);

    jtframe_arb_age #(
        .NSLOTS  (NSLOTS),
        .MAXWAIT (MAXWAIT),
        .AGEW    (AGEW)
    ) u_age (
        .clk      (clk),
        .rst_n    (rst_n),
        .slot_req (slot_req),
        .grant_en (grant_en),
        .win_idx  (win_idx),
        .aged_any (aged_any),
        .aged_idx (aged_idx)
    );

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rdy_d    = '0;
        dout_d   = dout_q;
        wdata_d  = wdata_q;
        rd_d     = rd_q;
        wr_d     = wr_q;
        is_wr_d  = is_wr_q;
        addr_d   = addr_q;
        mask_d   = mask_q;
        ptr_d    = ptr_q;
        complete = 1'b0;
        case (state_q)
            IDLE: begin
                // data_rdy here has no access to belong to and is dropped.
                if (grant_en) begin
                    grant_d = NSLOTS'(onehot(win_idx, NSLOTS));
                    addr_d  = slot_addr[int'(win_idx) * SDRAMW +: SDRAMW];
                    ptr_d   = (win_idx == IDXW'(NSLOTS - 1)) ? '0 : win_idx + 1'b1;
                    state_d = CMD;
                    if (win_idx == '0 && slot0_wen) begin
                        wr_d    = 1'b1;
                        rd_d    = 1'b0;
                        is_wr_d = 1'b1;
                        wdata_d = slot0_din;
                        mask_d  = slot0_wrmask;
                    end else begin
                        wr_d    = 1'b0;
                        rd_d    = 1'b1;
                        is_wr_d = 1'b0;
                        mask_d  = 2'b11;
                    end
                end
            end
            CMD: begin
                if (sdram_ack) begin
                    rd_d = 1'b0;
                    wr_d = 1'b0;
                    if (data_rdy) complete = 1'b1;
                    else          state_d  = DATA;
                end
            end
            DATA: begin
                if (data_rdy) complete = 1'b1;
            end
            default: state_d = IDLE;
        endcase
        if (complete) begin
            rdy_d   = grant_q;
            grant_d = '0;
            state_d = IDLE;
            if (!is_wr_q) dout_d = data_read;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            rdy_q   <= '0;
            dout_q  <= '0;
            wdata_q <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            is_wr_q <= 1'b0;
            addr_q  <= '0;
            mask_q  <= 2'b11;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            rdy_q   <= rdy_d;
            dout_q  <= dout_d;
            wdata_q <= wdata_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            is_wr_q <= is_wr_d;
            addr_q  <= addr_d;
            mask_q  <= mask_d;
            ptr_q   <= ptr_d;
        end
    end

    assign slot_grant   = grant_q;
    assign slot_rdy     = rdy_q;
    assign slot_dout    = dout_q;
    assign sdram_rd     = rd_q;
    assign sdram_wr     = wr_q;
    assign sdram_addr   = addr_q;
    assign data_write   = wdata_q;
    assign sdram_wrmask = mask_q;

endmodule
